apuf_majority_eval_seq: RTL and testbench

- Evaluation sequencer between the PicoBlaze PUF controller and the 64-stage arbiter PUF core.
- On a start request it latches the challenge and fires the APUF trigger N_EVAL times with the same challenge.
- It collects each arbiter response and returns the majority-voted bit, a stability flag and the ones count.
- Replaces the direct controller-to-APUF trigger path, so the controller gets noise-filtered responses plus reliability data.

---
 rtl/apuf_majority_eval_seq.sv | 216 +++++++++++++++++++++
 tb/tb_apuf_majority_eval_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apuf_majority_eval_seq.sv
// Evaluation sequencer for the arbiter PUF: fires N_EVAL triggers per request, majority-votes the responses.
// Define APUF_RAW_CAPTURE_EN to add the raw_bits port with the per-evaluation bit history.
module apuf_majority_eval_seq #(
   parameter int unsigned CHAL_SIZE = 64,
   parameter int unsigned N_EVAL    = 15,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned SETTLE    = 8,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAL_SIZE-1:0] chal_in,
   output logic [CHAL_SIZE-1:0] puf_chal,
   output logic                 puf_tig,
   input  logic                 puf_resp_ready,
   input  logic                 puf_resp_bit,
   output logic                 busy,
   output logic                 resp_ready,
   output logic                 resp_bit,
   output logic                 resp_stable,
   output logic                 resp_err,
   output logic [CNT_W-1:0]     ones_count
`ifdef APUF_RAW_CAPTURE_EN
   ,
   output logic [N_EVAL-1:0]    raw_bits
`endif
);

   localparam int unsigned SET_W = $clog2(SETTLE + 1);
   localparam int unsigned TO_W  = 8;

   if ((N_EVAL % 2) == 0 || N_EVAL < 1 || (2 ** CNT_W) <= N_EVAL ||
       SETTLE < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_err
      $error("apuf_majority_eval_seq: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_FIRE,
      S_GAP,
      S_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic                   start_q;
   logic                   accept;
   logic [CHAL_SIZE-1:0]   chal_q, chal_d;
   logic                   tig_q, tig_d;
   logic                   busy_q, busy_d;
   logic                   rdy_q, rdy_d;
   logic                   bit_q, bit_d;
   logic                   stable_q, stable_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       ones_q, ones_d;
   logic [CNT_W-1:0]       eval_q, eval_d;
   logic [SET_W-1:0]       settle_q, settle_d;
   logic [TO_W-1:0]        tout_q, tout_d;
   logic                   settle_done;
   logic                   timed_out;
`ifdef APUF_RAW_CAPTURE_EN
   logic [N_EVAL-1:0]      raw_q, raw_d;
`endif

   assign accept      = start & ~start_q;
   assign settle_done = ~puf_resp_ready & (settle_q == SET_W'(SETTLE - 1));
   assign timed_out   = (tout_q == TO_W'(TIMEOUT - 1));

   // Edge register tracks start even in reset, so a level held through reset is not an edge.
   always_ff @(posedge clk) begin
      start_q <= start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_SETTLE;
         S_SETTLE: if (settle_done) state_d = S_FIRE;
         S_FIRE:   if (puf_resp_ready || timed_out) state_d = S_GAP;
         S_GAP:    state_d = (eval_q == CNT_W'(N_EVAL)) ? S_DONE : S_SETTLE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values; a response in the final timeout clock still counts as a response.
   always_comb begin
      chal_d   = chal_q;
      busy_d   = busy_q;
      rdy_d    = rdy_q;
      bit_d    = bit_q;
      stable_d = stable_q;
      err_d    = err_q;
      ones_d   = ones_q;
      eval_d   = eval_q;
      settle_d = settle_q;
      tout_d   = tout_q;
`ifdef APUF_RAW_CAPTURE_EN
      raw_d    = raw_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               chal_d   = chal_in;
               busy_d   = 1'b1;
               rdy_d    = 1'b0;
               bit_d    = 1'b0;
               stable_d = 1'b0;
               err_d    = 1'b0;
               ones_d   = '0;
               eval_d   = '0;
               settle_d = '0;
               tout_d   = '0;
`ifdef APUF_RAW_CAPTURE_EN
               raw_d    = '0;
`endif
            end
         end
         S_SETTLE: begin
            tout_d = '0;
            if (puf_resp_ready) begin
               settle_d = '0;
            end else if (!settle_done) begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_FIRE: begin
            if (puf_resp_ready) begin
               ones_d = ones_q + CNT_W'(puf_resp_bit);
               eval_d = eval_q + 1'b1;
`ifdef APUF_RAW_CAPTURE_EN
               raw_d  = N_EVAL'({raw_q, puf_resp_bit});
`endif
            end else if (timed_out) begin
               err_d  = 1'b1;
               eval_d = eval_q + 1'b1;
`ifdef APUF_RAW_CAPTURE_EN
               raw_d  = N_EVAL'({raw_q, 1'b0});
`endif
            end else begin
               tout_d = tout_q + 1'b1;
            end
         end
         S_GAP: begin
            settle_d = '0;
         end
         S_DONE: begin
            bit_d    = (ones_q > CNT_W'(N_EVAL / 2));
            stable_d = ~err_q & ((ones_q == '0) | (ones_q == CNT_W'(N_EVAL)));
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
         end
         default: ;
      endcase
      tig_d = (state_d == S_FIRE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chal_q   <= '0;
         tig_q    <= 1'b0;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b0;
         bit_q    <= 1'b0;
         stable_q <= 1'b0;
         err_q    <= 1'b0;
         ones_q   <= '0;
         eval_q   <= '0;
         settle_q <= '0;
         tout_q   <= '0;
      end else begin
         chal_q   <= chal_d;
         tig_q    <= tig_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
         bit_q    <= bit_d;
         stable_q <= stable_d;
         err_q    <= err_d;
         ones_q   <= ones_d;
         eval_q   <= eval_d;
         settle_q <= settle_d;
         tout_q   <= tout_d;
      end
   end

`ifdef APUF_RAW_CAPTURE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q <= '0;
      end else begin
         raw_q <= raw_d;
      end
   end

   assign raw_bits = raw_q;
`endif

   assign puf_chal    = chal_q;
   assign puf_tig     = tig_q;
   assign busy        = busy_q;
   assign resp_ready  = rdy_q;
   assign resp_bit    = bit_q;
   assign resp_stable = stable_q;
   assign resp_err    = err_q;
   assign ones_count  = ones_q;

endmodule

// File: tb/tb_apuf_majority_eval_seq.sv
// Randomized bench for apuf_majority_eval_seq with a behavioural arbiter-PUF model and per-request reference.
`timescale 1ns/1ps
module tb_apuf_majority_eval_seq;

   localparam int CW     = 64;
   localparam int N      = 5;
   localparam int CNT_W  = 3;
   localparam int S      = 2;
   localparam int T      = 10;
   localparam int BUDGET = 400;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CW-1:0]     chal_in;
   logic [CW-1:0]     puf_chal;
   logic              puf_tig;
   logic              puf_resp_ready = 1'b0;
   logic              puf_resp_bit = 1'b0;
   logic              busy;
   logic              resp_ready;
   logic              resp_bit;
   logic              resp_stable;
   logic              resp_err;
   logic [CNT_W-1:0]  ones_count;
`ifdef APUF_RAW_CAPTURE_EN
   logic [N-1:0]      raw_bits;
`endif

   apuf_majority_eval_seq #(
      .CHAL_SIZE(CW), .N_EVAL(N), .CNT_W(CNT_W), .SETTLE(S), .TIMEOUT(T)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .chal_in(chal_in),
      .puf_chal(puf_chal), .puf_tig(puf_tig),
      .puf_resp_ready(puf_resp_ready), .puf_resp_bit(puf_resp_bit),
      .busy(busy), .resp_ready(resp_ready), .resp_bit(resp_bit),
      .resp_stable(resp_stable), .resp_err(resp_err), .ones_count(ones_count)
`ifdef APUF_RAW_CAPTURE_EN
      , .raw_bits(raw_bits)
`endif
   );

   always #5 clk = ~clk;

   // Per-request scenario: kind 0/1 = respond with that bit, 2 = never respond.
   int            kind [N];
   int            dly  [N];
   int            hold;
   int            req_id = 0;
   logic [CW-1:0] req_chal = '0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_width(input int i);
      return (kind[i] == 2) ? T : dly[i] + 1;
   endfunction

   // Trigger-low clocks after pulse i: one gap clock, then SETTLE clocks with ready low.
   function automatic int exp_gap(input int i);
      return (kind[i] == 2) ? S + 1 : S + ((hold > 1) ? hold : 1);
   endfunction

   // Arbiter model: responds dly clocks after the trigger rises, holds ready hold clocks after trigger falls.
   int m_req = 0, m_idx = 0, m_hi = 0, m_hold = 0;
   bit m_resp = 1'b0;
   always @(posedge clk) begin
      #1;
      if (m_req != req_id) begin
         m_req = req_id; m_idx = 0; m_hi = 0; m_resp = 1'b0;
      end
      if (puf_tig) begin
         if (!m_resp) begin
            m_hi++;
            if (m_idx < N && kind[m_idx] != 2 && m_hi > dly[m_idx]) begin
               puf_resp_ready = 1'b1;
               puf_resp_bit   = (kind[m_idx] == 1);
               m_resp         = 1'b1;
               m_hold         = hold;
            end
         end
      end else begin
         if (m_hi != 0) begin
            m_idx++; m_hi = 0; m_resp = 1'b0;
         end
         if (puf_resp_ready) begin
            if (m_hold == 0) puf_resp_ready = 1'b0;
            else m_hold--;
         end
      end
   end

   // Trigger observer: records pulse widths, gaps and challenge stability per request.
   int obs_w [N];
   int obs_g [N];
   int mon_req = 0, pulses = 0, hi_cnt = 0, low_cnt = 0, chal_bad = 0;
   bit prev_tig = 1'b0;
   always @(negedge clk) begin
      if (mon_req != req_id) begin
         mon_req = req_id; pulses = 0; hi_cnt = 0; low_cnt = 0; prev_tig = 1'b0; chal_bad = 0;
         for (int i = 0; i < N; i++) begin obs_w[i] = -1; obs_g[i] = -1; end
      end
      if (puf_tig) begin
         if (!prev_tig) begin
            if (pulses < N) obs_g[pulses] = low_cnt;
            pulses++;
            low_cnt = 0;
         end
         hi_cnt++;
      end else begin
         if (prev_tig) begin
            if (pulses >= 1 && pulses <= N) obs_w[pulses-1] = hi_cnt;
            hi_cnt = 0;
         end
         low_cnt++;
      end
      if (busy && puf_chal !== req_chal) chal_bad++;
      prev_tig = puf_tig;
   end

   task automatic set_all(input int k, input int d, input int h);
      for (int i = 0; i < N; i++) begin kind[i] = k; dly[i] = d; end
      hold = h;
   endtask

   // Issue one request from a negedge and check everything against the reference.
   task automatic run_req(input logic [CW-1:0] chal, input bit poke, input string tag);
      int lat, ones, exp_lat;
      bit err;
      logic [N-1:0] raw;
      req_id++;
      req_chal = chal;
      chal_in  = chal;
      start    = 1'b1;
      @(negedge clk);
      lat   = 1;
      start = 1'b0;
      check({tag, "/rdy_clr"}, 64'(resp_ready), 64'(0));
      check({tag, "/busy_set"}, 64'(busy), 64'(1));
      while (!resp_ready && lat < BUDGET) begin
         if (poke && lat == 7) begin
            start   = 1'b1;
            chal_in = ~chal;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;

      ones = 0; err = 1'b0; raw = '0; exp_lat = 1 + S + 2;
      for (int i = 0; i < N; i++) begin
         if (kind[i] == 1) ones++;
         if (kind[i] == 2) err = 1'b1;
         raw = {raw[N-2:0], (kind[i] == 1)};
         exp_lat += exp_width(i);
         if (i < N - 1) exp_lat += exp_gap(i);
      end

      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/busy_done"}, 64'(busy), 64'(0));
      check({tag, "/resp_bit"}, 64'(resp_bit), 64'(ones > N / 2));
      check({tag, "/ones"}, 64'(ones_count), 64'(ones));
      check({tag, "/stable"}, 64'(resp_stable), 64'(!err && (ones == 0 || ones == N)));
      check({tag, "/err"}, 64'(resp_err), 64'(err));
      check({tag, "/pulses"}, 64'(pulses), 64'(N));
      check({tag, "/chal_hold"}, 64'(chal_bad), 64'(0));
      for (int i = 0; i < N; i++) begin
         check({tag, "/tig_width"}, 64'(obs_w[i]), 64'(exp_width(i)));
         if (i > 0) check({tag, "/tig_gap"}, 64'(obs_g[i]), 64'(exp_gap(i - 1)));
      end
`ifdef APUF_RAW_CAPTURE_EN
      check({tag, "/raw"}, 64'(raw_bits), 64'(raw));
`endif
      repeat (10) @(negedge clk);
      check({tag, "/no_requeue"}, 64'(busy), 64'(0));
      check({tag, "/rdy_hold"}, 64'(resp_ready), 64'(1));
      check({tag, "/ones_hold"}, 64'(ones_count), 64'(ones));
   endtask

   initial begin
      int n, seen, x;
      rst = 1'b1; start = 1'b0; chal_in = '0;
      set_all(1, 0, 0);
      repeat (3) @(negedge clk);
      check("rst/tig", 64'(puf_tig), 64'(0));
      check("rst/busy", 64'(busy), 64'(0));
      check("rst/rdy", 64'(resp_ready), 64'(0));
      check("rst/bit", 64'(resp_bit), 64'(0));
      check("rst/stable", 64'(resp_stable), 64'(0));
      check("rst/err", 64'(resp_err), 64'(0));
      check("rst/ones", 64'(ones_count), 64'(0));
      check("rst/chal", puf_chal, 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      set_all(1, 0, 0);
      run_req(64'hDEADBEEF_01234567, 1'b0, "all_ones");
      set_all(0, 0, 0);
      kind = '{1, 0, 1, 0, 0};
      run_req(64'h0123_4567_89AB_CDEF, 1'b0, "pattern");
      set_all(2, 0, 0);
      run_req(64'hFFFF_0000_FFFF_0000, 1'b0, "timeout");
      set_all(1, 1, 0);
      run_req(64'hA5A5_5A5A_C3C3_3C3C, 1'b1, "busy_poke");
      set_all(1, 0, 6);
      run_req(64'h1111_2222_3333_4444, 1'b0, "ready_hold");
      set_all(0, T - 1, 0);
      run_req(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, "tie_resp");

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) begin
            x = $urandom_range(0, 9);
            kind[i] = (x < 2) ? 2 : x % 2;
            dly[i]  = $urandom_range(0, T - 1);
         end
         hold = $urandom_range(0, 7);
         run_req({$urandom, $urandom}, ($urandom_range(0, 3) == 0), "random");
      end

      // Reset during the third evaluation, with start held high across release.
      set_all(1, 3, 0);
      req_id++;
      req_chal = 64'hCAFE_F00D_0000_0003;
      chal_in  = req_chal;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(pulses == 3 && puf_tig) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("rst_fire/reach", 64'(n < BUDGET), 64'(1));
      start = 1'b1;
      rst   = 1'b1;
      @(negedge clk);
      check("rst_fire/tig", 64'(puf_tig), 64'(0));
      check("rst_fire/busy", 64'(busy), 64'(0));
      check("rst_fire/rdy", 64'(resp_ready), 64'(0));
      check("rst_fire/ones", 64'(ones_count), 64'(0));
      rst  = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy || puf_tig) seen++;
      end
      check("rst_fire/held_start", 64'(seen), 64'(0));
      start = 1'b0;
      repeat (3) @(negedge clk);

      set_all(1, 2, 1);
      kind[2] = 0;
      run_req(64'h7777_8888_9999_AAAA, 1'b0, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
